ethernet_tx_sequencer: RTL and testbench

- Streams one Ethernet frame from an AXI-stream-style source into the TX packet buffer of the ethernet controller core, then triggers transmission.
- Drives the core's MMIO slave port as a single master, sequenced as: poll TX ready, write frame words, write frame size, write send.
- Sits between a packet source (e.g. a NIC offload or test generator) and the core, replacing host-driven MMIO for the transmit path.

---
 rtl/ethernet_tx_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ethernet_tx_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_tx_sequencer.sv
// Streams one AXI-stream frame into the Ethernet core's TX buffer over MMIO:
// poll TX ready, write frame words, write frame size, then write send.
module ethernet_tx_sequencer #(
    parameter int unsigned axis_width_p  = 64,
    parameter int unsigned buf_size_p    = 2048,
    parameter logic [15:0] status_addr_p = 16'h0010,
    parameter logic [15:0] size_addr_p   = 16'h0018,
    parameter logic [15:0] send_addr_p   = 16'h001C,
    parameter logic [15:0] buf_base_p    = 16'h1800
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [axis_width_p-1:0]   s_data_i,
    input  logic [axis_width_p/8-1:0] s_keep_i,
    input  logic                      s_last_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [15:0]               addr_o,
    output logic                      write_en_o,
    output logic                      read_en_o,
    output logic [1:0]                op_size_o,
    output logic [axis_width_p-1:0]   write_data_o,
    input  logic [axis_width_p-1:0]   read_data_i,
    input  logic                      read_data_v_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      drop_o
);

    localparam int unsigned cnt_w_p  = $clog2(buf_size_p) + 1;
    localparam int unsigned keep_w_p = axis_width_p / 8;

    typedef enum logic [2:0] {
        IDLE,
        POLL_REQ,
        POLL_WAIT,
        STREAM,
        DRAIN,
        SIZE,
        SEND
    } state_t;

    state_t               state;
    logic [cnt_w_p-1:0]   byte_cnt;
    logic [cnt_w_p-1:0]   keep_cnt;
    logic                 accept;
    logic                 overflow;
    logic                 unused_read_bits;

    assign accept           = s_valid_i && s_ready_o;
    assign overflow         = (32'(byte_cnt) + 32'd8) > 32'(buf_size_p);
    assign unused_read_bits = ^read_data_i[axis_width_p-1:1];

    always_comb begin
        keep_cnt = '0;
        for (int unsigned i = 0; i < keep_w_p; i++) begin
            keep_cnt = keep_cnt + cnt_w_p'(s_keep_i[i]);
        end
    end

    // Outputs are loaded on the transition into a state, so every strobe
    // appears in the cycle after the decision that caused it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            s_ready_o    <= 1'b0;
            addr_o       <= '0;
            write_en_o   <= 1'b0;
            read_en_o    <= 1'b0;
            op_size_o    <= '0;
            write_data_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            drop_o       <= 1'b0;
        end else begin
            write_en_o <= 1'b0;
            read_en_o  <= 1'b0;
            done_o     <= 1'b0;
            drop_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid_i) begin
                        state     <= POLL_REQ;
                        busy_o    <= 1'b1;
                        read_en_o <= 1'b1;
                        addr_o    <= status_addr_p;
                        op_size_o <= 2'd2;
                    end
                end
                POLL_REQ: begin
                    state <= POLL_WAIT;
                end
                POLL_WAIT: begin
                    if (read_data_v_i) begin
                        if (read_data_i[0]) begin
                            state     <= STREAM;
                            s_ready_o <= 1'b1;
                        end else begin
                            state     <= POLL_REQ;
                            read_en_o <= 1'b1;
                            addr_o    <= status_addr_p;
                            op_size_o <= 2'd2;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (overflow) begin
                            // An oversized frame whose last beat is the overflowing one has nothing left to drain.
                            if (s_last_i) begin
                                state     <= IDLE;
                                s_ready_o <= 1'b0;
                                busy_o    <= 1'b0;
                                drop_o    <= 1'b1;
                                byte_cnt  <= '0;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            write_en_o   <= 1'b1;
                            addr_o       <= buf_base_p + 16'(byte_cnt);
                            op_size_o    <= 2'd3;
                            write_data_o <= s_data_i;
                            byte_cnt     <= byte_cnt + keep_cnt;
                            if (s_last_i) begin
                                state     <= SIZE;
                                s_ready_o <= 1'b0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last_i) begin
                        state     <= IDLE;
                        s_ready_o <= 1'b0;
                        busy_o    <= 1'b0;
                        drop_o    <= 1'b1;
                        byte_cnt  <= '0;
                    end
                end
                SIZE: begin
                    if (byte_cnt == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        drop_o <= 1'b1;
                    end else begin
                        state        <= SEND;
                        write_en_o   <= 1'b1;
                        addr_o       <= size_addr_p;
                        op_size_o    <= 2'd2;
                        write_data_o <= axis_width_p'(byte_cnt);
                    end
                end
                SEND: begin
                    state        <= IDLE;
                    busy_o       <= 1'b0;
                    write_en_o   <= 1'b1;
                    addr_o       <= send_addr_p;
                    op_size_o    <= 2'd2;
                    write_data_o <= axis_width_p'(1);
                    done_o       <= 1'b1;
                    byte_cnt     <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_tx_sequencer.sv
// Bench for ethernet_tx_sequencer: a transaction-level model predicts the MMIO
// access sequence of each frame and a monitor checks every strobe against it.
module tb_ethernet_tx_sequencer;

    localparam int BUF = 2048;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_last;
    logic        s_valid;
    logic        s_ready_o;
    logic [15:0] addr_o;
    logic        write_en_o;
    logic        read_en_o;
    logic [1:0]  op_size_o;
    logic [63:0] write_data_o;
    logic [63:0] read_data;
    logic        read_data_v;
    logic        busy_o;
    logic        done_o;
    logic        drop_o;

    always #5 clk = ~clk;

    ethernet_tx_sequencer #(
        .axis_width_p (64),
        .buf_size_p   (BUF),
        .status_addr_p(16'h0010),
        .size_addr_p  (16'h0018),
        .send_addr_p  (16'h001C),
        .buf_base_p   (16'h1800)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .s_data_i     (s_data),
        .s_keep_i     (s_keep),
        .s_last_i     (s_last),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready_o),
        .addr_o       (addr_o),
        .write_en_o   (write_en_o),
        .read_en_o    (read_en_o),
        .op_size_o    (op_size_o),
        .write_data_o (write_data_o),
        .read_data_i  (read_data),
        .read_data_v_i(read_data_v),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .drop_o       (drop_o)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [1:0]  op;
        logic [63:0] data;
        bit          send;
    } txn_t;

    txn_t        exp_q[$];
    logic [63:0] f_data[$];
    logic [7:0]  f_keep[$];
    bit          f_last[$];
    bit          stat_q[$];
    int          lat = 1;
    int          n_tests = 0;
    int          n_fail = 0;
    int          reads_seen = 0;
    int          dones_seen = 0;
    int          drops_seen = 0;
    int          exp_drops = 0;
    int          exp_dones = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input bit wr, input logic [15:0] a, input logic [1:0] op,
                        input logic [63:0] d, input bit s);
        txn_t t;
        t.wr = wr; t.addr = a; t.op = op; t.data = d; t.send = s;
        exp_q.push_back(t);
    endtask

    task automatic make_frame(input int nbeats, input logic [7:0] last_keep, input bit has_last);
        f_data.delete(); f_keep.delete(); f_last.delete();
        for (int i = 0; i < nbeats; i++) begin
            f_data.push_back({$urandom, $urandom});
            f_keep.push_back((has_last && i == nbeats - 1) ? last_keep : 8'hFF);
            f_last.push_back(has_last && i == nbeats - 1);
        end
    endtask

    // Expected MMIO sequence: status polls, one buffer write per beat that fits,
    // then size and send, or nothing further if the frame must be dropped.
    task automatic model(input int npolls);
        int cnt;
        bit dropped;
        cnt = 0; dropped = 0; exp_drops = 0; exp_dones = 0;
        repeat (npolls) push(1'b0, 16'h0010, 2'd2, 64'd0, 1'b0);
        foreach (f_data[i]) begin
            if (!dropped) begin
                if (cnt + 8 > BUF) dropped = 1;
                else begin
                    push(1'b1, 16'h1800 + 16'(cnt), 2'd3, f_data[i], 1'b0);
                    cnt += $countones(f_keep[i]);
                end
            end
            if (f_last[i]) begin
                if (dropped || cnt == 0) exp_drops = 1;
                else begin
                    push(1'b1, 16'h0018, 2'd2, 64'(cnt), 1'b0);
                    push(1'b1, 16'h001C, 2'd2, 64'd1, 1'b1);
                    exp_dones = 1;
                end
            end
        end
    endtask

    task automatic monitor();
        txn_t t;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (read_en_o || write_en_o) begin
                    check("rd_wr_exclusive", 64'(read_en_o & write_en_o), 64'd0);
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_access: got addr %0h wr %0b, expected none (t=%0t)",
                                 addr_o, write_en_o, $time);
                    end else begin
                        t = exp_q.pop_front();
                        check("txn", 64'({write_en_o, addr_o, op_size_o, done_o}),
                              64'({t.wr, t.addr, t.op, t.send}));
                        if (write_en_o) check("wdata", write_data_o, t.data);
                    end
                end else if (done_o) begin
                    check("done_without_send", 64'(done_o), 64'd0);
                end
                if (read_en_o) reads_seen++;
                if (done_o)    dones_seen++;
                if (drop_o)    drops_seen++;
            end
        end
    endtask

    task automatic responder();
        bit s;
        forever begin
            @(negedge clk);
            if (reset_n && read_en_o) begin
                s = (stat_q.size() > 0) ? stat_q.pop_front() : 1'b1;
                repeat (lat) @(posedge clk);
                #1;
                read_data      = {$urandom, $urandom};
                read_data[0]   = s;
                read_data_v    = 1'b1;
                @(posedge clk);
                #1 read_data_v = 1'b0;
            end
        end
    endtask

    // Called at posedge+1; drives the current frame, optionally idling between beats.
    task automatic send_frame(input int npolls, input int gap);
        int r0;
        bit seen_rdy, rdy, acc;
        r0 = reads_seen; seen_rdy = 0;
        foreach (f_data[i]) begin
            s_valid = 1'b1; s_data = f_data[i]; s_keep = f_keep[i]; s_last = f_last[i];
            acc = 0;
            for (int k = 0; k < 300 && !acc; k++) begin
                rdy = s_ready_o;
                if (rdy && !seen_rdy) begin
                    seen_rdy = 1;
                    check("polls_before_ready", 64'(reads_seen - r0), 64'(npolls));
                    check("busy_streaming", 64'(busy_o), 64'd1);
                end
                @(posedge clk);
                #1 acc = rdy;
            end
            if (!acc) begin
                n_tests++; n_fail++;
                $display("FAIL beat_timeout: got no accept, expected accept of beat %0d", i);
                s_valid = 1'b0;
                return;
            end
            if (gap > 0) begin
                s_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic run_frame(input int npolls, input int gap);
        int d0, p0;
        d0 = dones_seen; p0 = drops_seen;
        send_frame(npolls, gap);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("expected_all_seen", 64'(exp_q.size()), 64'd0);
        check("busy_idle", 64'(busy_o), 64'd0);
        check("done_count", 64'(dones_seen - d0), 64'(exp_dones));
        check("drop_count", 64'(drops_seen - p0), 64'(exp_drops));
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
        read_data = '0; read_data_v = 1'b0;
        fork
            monitor();
            responder();
        join_none
        #2 reset_n = 1'b0;
        #1;
        check("reset_ctrl", 64'({s_ready_o, write_en_o, read_en_o, done_o, drop_o, busy_o, op_size_o, addr_o}), 64'd0);
        check("reset_wdata", write_data_o, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: three beats, last keep 0x0F -> 20 bytes
        make_frame(3, 8'h0F, 1'b1);
        model(1);
        check("pin_addr0", 64'(exp_q[1].addr), 64'h1800);
        check("pin_addr2", 64'(exp_q[3].addr), 64'h1810);
        check("pin_size", exp_q[4].data, 64'd20);
        run_frame(1, 0);

        // 2: status not ready twice, slower read response
        stat_q = '{1'b0, 1'b0, 1'b1};
        lat = 2;
        make_frame(2, 8'h03, 1'b1);
        model(3);
        run_frame(3, 0);
        lat = 1;

        // 3: exactly full buffer, then one beat too many, then a frame needing DRAIN
        make_frame(256, 8'hFF, 1'b1);
        model(1);
        check("pin_full_size", exp_q[257].data, 64'd2048);
        run_frame(1, 0);
        make_frame(257, 8'hFF, 1'b1);
        model(1);
        check("pin_over_len", 64'(exp_q.size()), 64'd257);
        check("pin_over_drop", 64'(exp_drops), 64'd1);
        run_frame(1, 0);
        make_frame(259, 8'h01, 1'b1);
        model(1);
        run_frame(1, 0);

        // 4: single empty last beat
        make_frame(1, 8'h00, 1'b1);
        model(1);
        check("pin_empty_len", 64'(exp_q.size()), 64'd2);
        run_frame(1, 0);

        // 5: valid toggling every other cycle
        make_frame(6, 8'h7F, 1'b1);
        model(1);
        run_frame(1, 1);

        // 6: reset during STREAM after two beats
        make_frame(2, 8'hFF, 1'b0);
        model(1);
        send_frame(1, 0);
        #5 reset_n = 1'b0;
        #1;
        check("midreset_ctrl", 64'({s_ready_o, write_en_o, read_en_o, done_o, drop_o, busy_o, op_size_o, addr_o}), 64'd0);
        check("midreset_wdata", write_data_o, 64'd0);
        check("midreset_seen", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        make_frame(2, 8'hFF, 1'b1);
        model(1);
        check("pin_restart_addr", 64'(exp_q[1].addr), 64'h1800);
        run_frame(1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
